ad_capture_buffer: RTL and testbench



---
 rtl/ad_capture_buffer.sv | 191 +++++++++++++++++++
 tb/tb_ad_capture_buffer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_capture_buffer.sv
// Triggered capture of the ADC sample stream into a circular window buffer.
// The display reads the frozen window by column, with the trigger sample at column PRE_TRIG.
module ad_capture_buffer #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DEPTH        = 480,
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned PRE_TRIG     = 240,
  parameter int unsigned AUTO_TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] ad_data,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic              auto_mode,
  input  logic              arm,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              triggered,
  output logic              done
);

  localparam int unsigned POST_CNT = DEPTH - PRE_TRIG - 1;
  localparam int unsigned CNT_MAX  = (AUTO_TIMEOUT > DEPTH) ? AUTO_TIMEOUT : DEPTH;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_WAIT_TRIG,
    S_POSTFILL,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   trig_ptr_q, trig_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic [DATA_W-1:0]   level_q, level_d;
  logic                edge_sel_q, edge_sel_d;
  logic                triggered_q, triggered_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  logic                accept_c;
  logic                crossing_c;
  logic                auto_hit_c;
  logic                hit_c;
  logic [ADDR_W-1:0]   start_c;
  logic [ADDR_W:0]     sum_c;
  logic [ADDR_W-1:0]   phys_c;
  logic                in_range_c;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Sample acceptance and trigger qualification against the latched level/edge.
  always_comb begin
    accept_c   = sample_en && !rst &&
                 ((state_q == S_PREFILL) || (state_q == S_WAIT_TRIG) || (state_q == S_POSTFILL));
    crossing_c = edge_sel_q ? ((prev_q >= level_q) && (ad_data <  level_q))
                            : ((prev_q <  level_q) && (ad_data >= level_q));
    auto_hit_c = auto_mode && (cnt_q >= CNT_W'(AUTO_TIMEOUT - 1));
    hit_c      = crossing_c || auto_hit_c;
  end

  // Next-state and register updates.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    trig_ptr_d  = trig_ptr_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    level_d     = level_q;
    edge_sel_d  = edge_sel_q;
    triggered_d = triggered_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          level_d     = trig_level;
          edge_sel_d  = trig_edge;
          wr_ptr_d    = '0;
          cnt_d       = '0;
          triggered_d = 1'b0;
          state_d     = S_PREFILL;
        end
      end
      S_PREFILL: begin
        if (sample_en) begin
          if (cnt_q == CNT_W'(PRE_TRIG - 1)) begin
            cnt_d   = '0;
            state_d = S_WAIT_TRIG;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_WAIT_TRIG: begin
        if (sample_en) begin
          if (hit_c) begin
            trig_ptr_d  = wr_ptr_q;
            triggered_d = 1'b1;
            if (POST_CNT == 0) begin
              cnt_d   = '0;
              state_d = S_DONE;
            end else begin
              cnt_d   = CNT_W'(POST_CNT);
              state_d = S_POSTFILL;
            end
          end else if (cnt_q < CNT_W'(AUTO_TIMEOUT - 1)) begin
            // Saturates so an endless normal-mode wait cannot wrap the count.
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_POSTFILL: begin
        if (sample_en) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept_c) begin
      wr_ptr_d = (wr_ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + ADDR_W'(1);
      prev_d   = ad_data;
    end

    busy_d = (state_d == S_PREFILL) || (state_d == S_WAIT_TRIG) || (state_d == S_POSTFILL);
    done_d = (state_d == S_DONE);
  end

  // Column-to-physical mapping: window starts PRE_TRIG samples before the trigger, mod DEPTH.
  always_comb begin
    start_c    = (trig_ptr_q >= ADDR_W'(PRE_TRIG)) ? trig_ptr_q - ADDR_W'(PRE_TRIG)
                                                   : trig_ptr_q + ADDR_W'(DEPTH - PRE_TRIG);
    sum_c      = {1'b0, start_c} + {1'b0, rd_addr};
    phys_c     = (sum_c >= (ADDR_W + 1)'(DEPTH)) ? ADDR_W'(sum_c - (ADDR_W + 1)'(DEPTH))
                                                 : sum_c[ADDR_W-1:0];
    in_range_c = ({1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH));
    rd_data_d  = in_range_c ? mem[phys_c] : '0;
  end

  // Sample storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      mem[wr_ptr_q] <= ad_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      trig_ptr_q  <= '0;
      cnt_q       <= '0;
      prev_q      <= '0;
      level_q     <= '0;
      edge_sel_q  <= 1'b0;
      triggered_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      trig_ptr_q  <= trig_ptr_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      level_q     <= level_d;
      edge_sel_q  <= edge_sel_d;
      triggered_q <= triggered_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign triggered = triggered_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ad_capture_buffer.sv
// Directed bench for ad_capture_buffer: ramp, triangle, auto, normal, abort and gapped captures.
module tb_ad_capture_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_en;
  logic [7:0] ad_data;
  logic [7:0] trig_level;
  logic       trig_edge;
  logic       auto_mode;
  logic       arm;
  logic [8:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       triggered;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  ad_capture_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .ad_data    (ad_data),
    .trig_level (trig_level),
    .trig_edge  (trig_edge),
    .auto_mode  (auto_mode),
    .arm        (arm),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .triggered  (triggered),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish (observed timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] d);
    sample_en = 1'b1;
    ad_data   = d;
    tick();
    sample_en = 1'b0;
  endtask

  // Strobe then two idle cycles carrying junk data that must not be taken.
  task automatic put_gap(input logic [7:0] d);
    put(d);
    ad_data = 8'hAA;
    tick();
    tick();
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input int a, input int exp_v);
    rd_addr = 9'(a);
    tick();
    chk(tag, 32'(rd_data), 32'(exp_v));
  endtask

  function automatic logic [7:0] tri_v(input int n);
    int m;
    m = n % 510;
    return (m < 256) ? 8'(m) : 8'(510 - m);
  endfunction

  initial begin
    rst        = 1'b1;
    sample_en  = 1'b0;
    ad_data    = '0;
    trig_level = '0;
    trig_edge  = 1'b0;
    auto_mode  = 1'b0;
    arm        = 1'b0;
    rd_addr    = '0;

    // Reset state
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_trig", 32'(triggered), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd", 32'(rd_data), 0);
    rst = 1'b0;

    // 1: rising ramp, trigger on n=356
    trig_level = 8'd100;
    trig_edge  = 1'b0;
    pulse_arm();
    chk("s1_busy_arm", 32'(busy), 1);
    chk("s1_trig_arm", 32'(triggered), 0);
    for (int n = 0; n < 356; n++) put(8'(n));
    chk("s1_no_trig_355", 32'(triggered), 0);
    put(8'(356));
    chk("s1_trig_356", 32'(triggered), 1);
    for (int n = 357; n < 595; n++) put(8'(n));
    chk("s1_not_done_594", 32'(done), 0);
    chk("s1_busy_594", 32'(busy), 1);
    put(8'(595));
    chk("s1_done_595", 32'(done), 1);
    chk("s1_idle_busy", 32'(busy), 0);
    chk_rd("s1_rd240", 240, 100);
    chk_rd("s1_rd239", 239, 99);
    chk_rd("s1_rd0", 0, 116);
    chk_rd("s1_rd479", 479, 83);
    chk_rd("s1_rd480", 480, 0);
    chk_rd("s1_rd511", 511, 0);
    rd_addr = 9'd240;
    tick();
    rd_addr = 9'd0;
    #2;
    chk("s1_latency_hold", 32'(rd_data), 100);
    tick();
    chk("s1_latency_new", 32'(rd_data), 116);
    for (int i = 0; i < 20; i++) put(8'hEE);
    chk("s1_done_hold", 32'(done), 1);
    for (int a = 0; a < 480; a++) chk_rd($sformatf("s1_win%0d", a), a, (116 + a) % 256);

    // 2: falling triangle, level 128, trigger on n=383 (128 -> 127)
    trig_level = 8'd128;
    trig_edge  = 1'b1;
    pulse_arm();
    chk("s2_trig_cleared", 32'(triggered), 0);
    chk("s2_done_cleared", 32'(done), 0);
    trig_level = 8'd0;
    trig_edge  = 1'b0;
    for (int n = 0; n < 383; n++) put(tri_v(n));
    chk("s2_no_trig_382", 32'(triggered), 0);
    put(tri_v(383));
    chk("s2_trig_383", 32'(triggered), 1);
    for (int n = 384; n < 622; n++) put(tri_v(n));
    chk("s2_not_done", 32'(done), 0);
    put(tri_v(622));
    chk("s2_done", 32'(done), 1);
    chk_rd("s2_rd240", 240, 127);
    chk_rd("s2_rd239", 239, 128);
    chk_rd("s2_rd241", 241, 126);
    chk_rd("s2_rd0", 0, 143);
    chk_rd("s2_rd479", 479, 112);

    // 3: auto mode, constant 50 below level 100
    trig_level = 8'd100;
    trig_edge  = 1'b0;
    auto_mode  = 1'b1;
    pulse_arm();
    for (int i = 0; i < 240; i++) put(8'd50);
    for (int i = 0; i < 999; i++) put(8'd50);
    chk("s3_no_trig_999", 32'(triggered), 0);
    put(8'd50);
    chk("s3_trig_1000", 32'(triggered), 1);
    for (int i = 0; i < 238; i++) put(8'd50);
    chk("s3_not_done", 32'(done), 0);
    put(8'd50);
    chk("s3_done", 32'(done), 1);
    for (int a = 0; a < 480; a++) chk_rd($sformatf("s3_win%0d", a), a, 50);

    // 4: normal mode, no crossing for 5000 samples
    auto_mode = 1'b0;
    pulse_arm();
    for (int i = 0; i < 5000; i++) begin
      put(8'd50);
      if (i % 100 == 99) begin
        chk($sformatf("s4_busy%0d", i), 32'(busy), 1);
        chk($sformatf("s4_trig%0d", i), 32'(triggered), 0);
        chk($sformatf("s4_done%0d", i), 32'(done), 0);
      end
    end

    // 5a: arm during POSTFILL is ignored
    put(8'd150);
    chk("s5_trig", 32'(triggered), 1);
    for (int i = 0; i < 10; i++) put(8'd7);
    pulse_arm();
    chk("s5_arm_ignored_trig", 32'(triggered), 1);
    chk("s5_arm_ignored_busy", 32'(busy), 1);
    for (int i = 0; i < 228; i++) put(8'd7);
    chk("s5_not_done", 32'(done), 0);
    put(8'd7);
    chk("s5_done", 32'(done), 1);

    // 5b: reset during POSTFILL
    pulse_arm();
    for (int i = 0; i < 240; i++) put(8'd50);
    put(8'd150);
    chk("s5b_trig", 32'(triggered), 1);
    for (int i = 0; i < 5; i++) put(8'd7);
    rd_addr = 9'd240;
    pulse_rst();
    chk("s5b_rst_busy", 32'(busy), 0);
    chk("s5b_rst_trig", 32'(triggered), 0);
    chk("s5b_rst_done", 32'(done), 0);
    chk("s5b_rst_rd", 32'(rd_data), 0);

    // 5c: fresh capture after reset
    pulse_arm();
    chk("s5c_busy", 32'(busy), 1);
    for (int n = 0; n < 240; n++) put(8'(n));
    put(8'd0);
    chk("s5c_no_trig", 32'(triggered), 0);
    put(8'd200);
    chk("s5c_trig", 32'(triggered), 1);
    for (int i = 0; i < 238; i++) put(8'd9);
    chk("s5c_not_done", 32'(done), 0);
    put(8'd9);
    chk("s5c_done", 32'(done), 1);
    chk_rd("s5c_rd240", 240, 200);
    chk_rd("s5c_rd239", 239, 0);
    chk_rd("s5c_rd238", 238, 239);
    chk_rd("s5c_rd0", 0, 1);
    chk_rd("s5c_rd479", 479, 9);

    // 6: gapped strobe reproduces scenario 1
    pulse_rst();
    trig_level = 8'd100;
    trig_edge  = 1'b0;
    pulse_arm();
    for (int n = 0; n < 356; n++) put_gap(8'(n));
    chk("s6_no_trig_355", 32'(triggered), 0);
    put_gap(8'(356));
    chk("s6_trig_356", 32'(triggered), 1);
    for (int n = 357; n < 595; n++) put_gap(8'(n));
    chk("s6_not_done", 32'(done), 0);
    put_gap(8'(595));
    chk("s6_done", 32'(done), 1);
    for (int i = 0; i < 10; i++) put(8'hEE);
    for (int a = 0; a < 480; a++) chk_rd($sformatf("s6_win%0d", a), a, (116 + a) % 256);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
